// File: rtl/nexys_starship_pkg.sv
// Shared constants for the Nexys Starship game blocks: state encodings,
// LFSR polynomial and lane names.
package nexys_starship_pkg;

   localparam int unsigned LFSR_W  = 16;
   localparam int unsigned TIMER_W = 16;

   // One-hot game state encodings, bit order {over, play, init}
   localparam logic [2:0] INIT = 3'b001;
   localparam logic [2:0] PLAY = 3'b010;
   localparam logic [2:0] OVER = 3'b100;

   typedef enum logic [2:0] {
      ST_INIT = INIT,
      ST_PLAY = PLAY,
      ST_OVER = OVER
   } state_e;

   // Galois feedback mask for the 16-bit right-shifting LFSR
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   // Default lane indices for the four-lane layout
   localparam int unsigned TOP    = 0;
   localparam int unsigned BOTTOM = 1;
   localparam int unsigned LEFT   = 2;
   localparam int unsigned RIGHT  = 3;

   // One Galois step: shift right, fold the taps back in when a 1 falls out
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ LFSR_TAPS;
      return n;
   endfunction

endpackage

// File: rtl/nexys_starship_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module nexys_starship_lfsr
   import nexys_starship_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              Clk,
   input  logic              Reset,
   output logic [LFSR_W-1:0] state
);

   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

   // Advance one step every clock, regardless of game state
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= SEED_EFF;
      else       state <= lfsr_step(state);
   end

endmodule

// File: rtl/nexys_starship_lanes.sv
// Multi-lane monster controller: game FSM, random spawning, per-lane
// survival timers, player kills and a saturating kill score.
module nexys_starship_lanes
   import nexys_starship_pkg::*;
#(
   parameter int unsigned       NUM_LANES     = 4,
   parameter logic [8:0]        SPAWN_THRESH  = 9'd3,
   parameter int unsigned       TIMEOUT_TICKS = 200,
   parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
   parameter int unsigned       SCORE_W       = 10
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 play_flag,
   input  logic                 restart,
   input  logic                 tick,
   input  logic [NUM_LANES-1:0] kill,
   output logic                 q_Init,
   output logic                 q_Play,
   output logic                 q_Over,
   output logic [NUM_LANES-1:0] lane_monster,
   output logic                 game_over,
   output logic [SCORE_W-1:0]   score
);

   localparam int unsigned LANE_W = $clog2(NUM_LANES);
   localparam int unsigned CNT_W  = LANE_W + 1;
   localparam int unsigned SUM_W  = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_TICKS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   state_e               state_q;
   logic [LFSR_W-1:0]    lfsr_q;
   logic [TIMER_W-1:0]   timer_q [NUM_LANES];

   logic [LANE_W-1:0]    sel_c;
   logic                 draw_hit_c;
   logic [NUM_LANES-1:0] kill_hit_c;
   logic [NUM_LANES-1:0] spawn_c;
   logic [NUM_LANES-1:0] expire_c;
   logic [NUM_LANES-1:0] lanes_next_c;
   logic [CNT_W-1:0]     kills_c;
   logic [SUM_W-1:0]     sum_c;
   logic [SCORE_W-1:0]   score_next_c;
   logic                 unused_lfsr_c;

   nexys_starship_lfsr #(
      .SEED  (SEED)
   ) u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .state (lfsr_q)
   );

   // Low byte is the spawn draw, top bits pick the lane; the rest is spare
   assign sel_c         = lfsr_q[LFSR_W-1 -: LANE_W];
   assign draw_hit_c    = ({1'b0, lfsr_q[7:0]} < SPAWN_THRESH);
   assign unused_lfsr_c = ^lfsr_q;

   // Per-lane kill, spawn and expiry decisions for the current cycle
   always_comb begin
      kill_hit_c = kill & lane_monster;
      spawn_c    = '0;
      expire_c   = '0;
      if (tick && draw_hit_c && !lane_monster[sel_c]) spawn_c[sel_c] = 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (tick && lane_monster[i] && !kill[i] && (timer_q[i] == TIMER_LAST))
            expire_c[i] = 1'b1;
      end
      lanes_next_c = (lane_monster & ~kill_hit_c) | spawn_c;
   end

   // Score plus the number of kills landed this cycle, clamped at all-ones
   always_comb begin
      kills_c = '0;
      for (int i = 0; i < NUM_LANES; i++) kills_c = kills_c + CNT_W'(kill_hit_c[i]);
      sum_c        = SUM_W'(score) + SUM_W'(kills_c);
      score_next_c = (sum_c > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(sum_c);
   end

   assign {q_Over, q_Play, q_Init} = state_q;

   // Game FSM with lane, timer and score registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_INIT;
         lane_monster <= '0;
         game_over    <= 1'b0;
         score        <= '0;
         for (int i = 0; i < NUM_LANES; i++) timer_q[i] <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               lane_monster <= '0;
               game_over    <= 1'b0;
               score        <= '0;
               for (int i = 0; i < NUM_LANES; i++) timer_q[i] <= '0;
               if (play_flag) state_q <= ST_PLAY;
            end
            ST_PLAY: begin
               lane_monster <= lanes_next_c;
               score        <= score_next_c;
               for (int i = 0; i < NUM_LANES; i++) begin
                  if (kill_hit_c[i] || spawn_c[i])
                     timer_q[i] <= '0;
                  else if (tick && lane_monster[i])
                     timer_q[i] <= timer_q[i] + TIMER_W'(1);
               end
               if (|expire_c) begin
                  state_q   <= ST_OVER;
                  game_over <= 1'b1;
               end
            end
            ST_OVER: begin
               // Everything stays frozen for display until restart
               if (restart) begin
                  state_q      <= ST_INIT;
                  lane_monster <= '0;
                  game_over    <= 1'b0;
                  score        <= '0;
                  for (int i = 0; i < NUM_LANES; i++) timer_q[i] <= '0;
               end
            end
            default: begin
               state_q   <= ST_INIT;
               game_over <= 1'b0;
            end
         endcase
      end
   end

endmodule
